// File: rtl/spi_slave.sv
// SPI mode-0 target oversampled in the clk domain; byte-wide valid/ready TX and RX.
// Define SPI_SLAVE_RXFIFO_EN for a 4-entry RX FIFO instead of a single holding register.
module spi_slave #(
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic       busy
);

  localparam int S = SYNC_STAGES;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic [S:0]   sclk_s_q;
  logic [S:0]   cs_s_q;
  logic [S-1:0] mosi_s_q;

  // cs chain resets to "selected" so a reset inside a frame never fakes a falling edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_s_q <= '0;
      cs_s_q   <= '0;
      mosi_s_q <= '0;
    end else begin
      sclk_s_q <= {sclk_s_q[S-1:0], spi_clk};
      cs_s_q   <= {cs_s_q[S-1:0], spi_cs};
      mosi_s_q <= {mosi_s_q[S-2:0], spi_mosi};
    end
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_rise = sclk_s_q[S-1] & ~sclk_s_q[S];
  assign sclk_fall = ~sclk_s_q[S-1] & sclk_s_q[S];
  assign cs_rise   = cs_s_q[S-1] & ~cs_s_q[S];
  assign cs_fall   = ~cs_s_q[S-1] & cs_s_q[S];

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] rx_sh_q, tx_sh_q, hold_q;
  logic       hold_full_q, miso_q, busy_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (tx_valid && !hold_full_q) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end
      if (cs_rise) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        rx_sh_q <= '0;
        tx_sh_q <= '0;
        miso_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            miso_q <= 1'b0;
            if (cs_fall) begin
              state_q <= LOAD;
              busy_q  <= 1'b1;
            end
          end
          LOAD: begin
            if (hold_full_q) begin
              tx_sh_q     <= hold_q;
              miso_q      <= hold_q[7];
              hold_full_q <= 1'b0;
            end else begin
              tx_sh_q <= IDLE_BYTE;
              miso_q  <= IDLE_BYTE[7];
            end
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
          SHIFT: begin
            miso_q <= tx_sh_q[7];
            if (cnt_q == 4'd8) begin
              state_q <= LOAD;
            end else if (sclk_rise) begin
              rx_sh_q <= {rx_sh_q[6:0], mosi_s_q[S-1]};
              cnt_q   <= cnt_q + 4'd1;
            end else if (sclk_fall && cnt_q != 4'd0) begin
              // cnt 0 means the trailing fall of the previous byte
              tx_sh_q <= {tx_sh_q[6:0], 1'b0};
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign spi_miso = miso_q;
  assign busy     = busy_q;
  assign tx_ready = ~hold_full_q;

  logic byte_done, pop, ovr_set, ovr_q;
  assign byte_done = (state_q == SHIFT) && (cnt_q == 4'd8);
  assign pop       = rx_valid && rx_ready;

`ifdef SPI_SLAVE_RXFIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wp_q, rp_q;
  logic [2:0] fcnt_q;
  logic       full, accept;

  assign full    = (fcnt_q == 3'd4);
  assign accept  = byte_done && (!full || pop);
  assign ovr_set = byte_done && full && !pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (accept) begin
        mem_q[wp_q] <= rx_sh_q;
        wp_q        <= wp_q + 2'd1;
      end
      if (pop) rp_q <= rp_q + 2'd1;
      if (accept && !pop)      fcnt_q <= fcnt_q + 3'd1;
      else if (!accept && pop) fcnt_q <= fcnt_q - 3'd1;
    end
  end

  assign rx_data  = mem_q[rp_q];
  assign rx_valid = (fcnt_q != 3'd0);
`else
  logic [7:0] rx_data_q;
  logic       rx_valid_q;

  assign ovr_set = byte_done && rx_valid_q && !rx_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (byte_done && !ovr_set) begin
      rx_data_q  <= rx_sh_q;
      rx_valid_q <= 1'b1;
    end else if (pop) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          ovr_q <= 1'b0;
    else if (ovr_set)     ovr_q <= 1'b1;
    else if (overrun_clr) ovr_q <= 1'b0;
  end

  assign overrun = ovr_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-banged SPI master, immediate-assertion checks.
// Overrun depth follows SPI_SLAVE_RXFIFO_EN.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       resetn;
  logic       spi_clk, spi_cs, spi_mosi, spi_miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic       overrun, overrun_clr, busy;

  int passed = 0;
  int total  = 0;

`ifdef SPI_SLAVE_RXFIFO_EN
  localparam int NOVR = 5;
`else
  localparam int NOVR = 2;
`endif

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk), .resetn(resetn),
    .spi_clk(spi_clk), .spi_cs(spi_cs),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic cs_assert();
    spi_cs = 1'b0;
    tick(8);
  endtask

  task automatic cs_release();
    tick(8);
    spi_cs = 1'b1;
    tick(10);
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nbits,
                          output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      tick(8);
      mi = {mi[6:0], spi_miso};
      spi_clk = 1'b1;
      tick(8);
      spi_clk = 1'b0;
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_miso"}, spi_miso, 8'h0);
    check({pfx, "_txrdy"}, tx_ready, 8'h1);
    check({pfx, "_rxv"}, rx_valid, 8'h0);
    check({pfx, "_rxd"}, rx_data, 8'h00);
    check({pfx, "_ovr"}, overrun, 8'h0);
    check({pfx, "_busy"}, busy, 8'h0);
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] b;
    resetn = 1'b0;
    spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; overrun_clr = 1'b0;
    tick(3);
    check_reset_vals("rst");
    resetn = 1'b1;
    tick(5);

    push_tx(8'hA5);
    check("single_txrdy_lo", tx_ready, 8'h0);
    cs_assert();
    check("single_busy", busy, 8'h1);
    check("single_txrdy_hi", tx_ready, 8'h1);
    spi_bits(8'h3C, 8, mi);
    check("single_miso", mi, 8'hA5);
    check("single_rxv", rx_valid, 8'h1);
    check("single_rxd", rx_data, 8'h3C);
    pop_rx();
    check("single_pop", rx_valid, 8'h0);
    cs_release();
    check("idle_busy", busy, 8'h0);
    check("idle_miso", spi_miso, 8'h0);

    cs_assert();
    spi_bits(8'h00, 8, mi);
    check("empty_miso", mi, 8'hFF);
    check("empty_rxd", rx_data, 8'h00);
    check("empty_rxv", rx_valid, 8'h1);
    pop_rx();
    cs_release();

    push_tx(8'h11);
    cs_assert();
    check("multi_txrdy", tx_ready, 8'h1);
    push_tx(8'h22);
    spi_bits(8'h01, 8, mi);
    check("multi_miso0", mi, 8'h11);
    check("multi_rxv0", rx_valid, 8'h1);
    check("multi_rxd0", rx_data, 8'h01);
    pop_rx();
    spi_bits(8'h02, 8, mi);
    check("multi_miso1", mi, 8'h22);
    check("multi_rxv1", rx_valid, 8'h1);
    check("multi_rxd1", rx_data, 8'h02);
    pop_rx();
    cs_release();
    check("multi_txrdy_end", tx_ready, 8'h1);

    cs_assert();
    for (int i = 0; i < NOVR; i++) begin
      b = 8'h70 + 8'(i);
      spi_bits(b, 8, mi);
    end
    cs_release();
    check("ovr_set", overrun, 8'h1);
    for (int i = 0; i < NOVR - 1; i++) begin
      b = 8'h70 + 8'(i);
      check("ovr_rxv", rx_valid, 8'h1);
      check("ovr_rxd", rx_data, b);
      pop_rx();
    end
    check("ovr_drained", rx_valid, 8'h0);
    check("ovr_sticky", overrun, 8'h1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("ovr_clr", overrun, 8'h0);

    cs_assert();
    spi_bits(8'hFF, 5, mi);
    cs_release();
    check("abort_rxv", rx_valid, 8'h0);
    check("abort_busy", busy, 8'h0);
    cs_assert();
    spi_bits(8'h5A, 8, mi);
    check("abort_rxv2", rx_valid, 8'h1);
    check("abort_rxd", rx_data, 8'h5A);
    check("abort_miso", mi, 8'hFF);
    pop_rx();
    cs_release();

    push_tx(8'hC3);
    cs_assert();
    spi_bits(8'hAA, 3, mi);
    resetn = 1'b0;
    tick(2);
    check_reset_vals("midrst");
    resetn = 1'b1;
    tick(4);
    spi_bits(8'hAA, 5, mi);
    check("midrst_busy", busy, 8'h0);
    check("midrst_rxv", rx_valid, 8'h0);
    check("midrst_miso", spi_miso, 8'h0);
    cs_release();
    cs_assert();
    check("post_busy", busy, 8'h1);
    spi_bits(8'h96, 8, mi);
    check("post_miso", mi, 8'hFF);
    check("post_rxv", rx_valid, 8'h1);
    check("post_rxd", rx_data, 8'h96);
    pop_rx();
    cs_release();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 target that sits on the far side of the SoC SPI master (`spi_clk`/`spi_mosi`/`spi_miso`/`spi_cs`), for bench loopback and for a second board acting as a peripheral. It oversamples the SPI pins in the system clock domain, shifts bytes MSB-first in both directions and exchanges them with local logic over valid/ready byte interfaces.

## Interface
- `IDLE_BYTE`, 8'hFF, byte shifted out when no TX byte is queued.
- `SYNC_STAGES`, 2, synchronizer depth on `spi_clk`, `spi_cs`, `spi_mosi` (min 2).
- `clk`  in  1  system clock; one clock, all logic on rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `spi_clk`  in  1  SPI clock from master, idle low, ≤ clk/8.
- `spi_cs`  in  1  chip select, active low.
- `spi_mosi`  in  1  master-out data.
- `spi_miso`  out  1  slave-out data; 0 while `spi_cs` high.
- `tx_data`  in  8  next byte to send.
- `tx_valid`  in  1  `tx_data` offered.
- `tx_ready`  out  1  TX holding register empty.
- `rx_data`  out  8  received byte.
- `rx_valid`  out  1  `rx_data` valid.
- `rx_ready`  in  1  consumer accepts `rx_data`.
- `overrun`  out  1  sticky: a received byte was dropped.
- `overrun_clr`  in  1  clears `overrun`.
- `busy`  out  1  frame in progress (synced `spi_cs` low).

## Operation
- All three SPI inputs pass through `SYNC_STAGES` flops; edges detected from last two synced stages.
- FSM: IDLE → LOAD on synced `spi_cs` falling; LOAD → SHIFT after one cycle; SHIFT → LOAD after 8th sampled bit; any state → IDLE on synced `spi_cs` rising.
- LOAD: TX shift register ← holding register if full (holding register emptied, `tx_ready` rises next cycle), else `IDLE_BYTE`; bit counter ← 0; `spi_miso` ← bit 7.
- SHIFT: synced `spi_clk` rise → shift in `spi_mosi` (MSB first), counter+1; synced fall → shift TX register, `spi_miso` ← next bit. No fall-shift after 8th bit (LOAD supplies next byte's MSB).
- Byte complete (counter 8): byte written to RX storage; if storage full, byte dropped, `overrun` set.
- `tx_valid && tx_ready` captures `tx_data`; `tx_ready` low next cycle.
- `rx_valid && rx_ready` pops; `rx_valid` drops next cycle unless more data stored.
- `spi_cs` deassert mid-byte: partial RX byte discarded, unsent TX bits discarded (consumed TX byte not restored), counter cleared.
- `overrun_clr` and a new overrun in same cycle: `overrun` stays 1.
- Reset mid-frame: all state cleared; after release, FSM waits in IDLE until next `spi_cs` falling edge.

## Timing
- Reset values: `spi_miso`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `overrun`=0, `busy`=0.
- Pin-to-detect latency: SYNC_STAGES+1 clk.
- `spi_miso` first bit valid SYNC_STAGES+2 clk after `spi_cs` falls; master must wait ≥ that (4 clk default) before first `spi_clk` rise.
- `rx_valid` asserts SYNC_STAGES+2 clk after 8th `spi_clk` rising edge.
- `spi_miso` updates SYNC_STAGES+2 clk after each `spi_clk` falling edge; half SPI period ≥ 4 clk guarantees setup at master.
- `busy` follows `spi_cs` with SYNC_STAGES+1 clk latency.

## Configuration
- `SPI_SLAVE_RXFIFO_EN` defined: RX storage is 4-entry FIFO; `rx_data` shows head; overrun only when 4 bytes unread and a 5th completes. Simultaneous push and pop when full: pop frees slot, push accepted, no overrun.
- Undefined: RX storage is single holding register; overrun when a byte completes while `rx_valid`=1 and `rx_ready`=0; a byte completing in the same cycle as a pop is accepted.

## Test plan
- Reset: assert `resetn`=0 mid-frame → all outputs at reset values; next frame operates normally.
- Single byte: queue 8'hA5, master sends 8'h3C → master reads 8'hA5, `rx_data`=8'h3C with `rx_valid`, `tx_ready` back to 1.
- Empty TX: no byte queued, master sends 8'h00 → master reads 8'hFF (`IDLE_BYTE`).
- Multi-byte frame: queue 8'h11 then 8'h22 on `tx_ready`, master sends 8'h01, 8'h02 in one CS → reads 8'h11, 8'h22; RX delivers 8'h01, 8'h02 in order.
- Overrun: `rx_ready`=0, master sends 2 bytes (5 with FIFO) → `overrun`=1, first stored byte(s) intact; `overrun_clr` pulse → 0.
- Abort: `spi_cs` high after 5 bits → no `rx_valid`, counter cleared; next full byte 8'h5A received correctly.
